// File: rtl/rc_servo_pkg.sv
// Shared types and default timing for the RC servo PWM link (generator and receiver).
package rc_servo_pkg;

    localparam int US_CNT_W = 12;
    localparam int POS_W    = 8;
    localparam int DIFF_W   = US_CNT_W + 1;

    localparam int DEF_TICKS_PER_US = 50;
    localparam int DEF_MIN_PULSE_US = 500;
    localparam int DEF_MAX_PULSE_US = 2500;
    localparam int DEF_POS_MIN_US   = 1000;
    localparam int DEF_TIMEOUT_US   = 25000;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } rx_state_e;

    // Width in us to 0..255 position, 4 us per step above pos_min_us.
    function automatic logic [POS_W-1:0] width_to_pos(input logic [US_CNT_W-1:0] width,
                                                      input int pos_min_us);
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W-1:0] scaled;
        diff   = $signed({1'b0, width}) - $signed(DIFF_W'(pos_min_us));
        scaled = diff >>> 2;
        if (diff < 13'sd0) begin
            return '0;
        end else if (scaled > 13'sd255) begin
            return '1;
        end else begin
            return scaled[POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rc_servo_sync.sv
// Two-flop synchroniser plus one delay stage; yields the clean level and its edges.
module rc_servo_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // NOTE: non-blocking assignments make each stage capture the previous stage's old value;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            dly_q  <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~dly_q;
    assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/rc_servo_pwm_rx.sv
// Servo PWM receiver: measures pulse high time in us, maps it to a position, tracks lock.
module rc_servo_pwm_rx
    import rc_servo_pkg::*;
#(
    parameter int TICKS_PER_US = DEF_TICKS_PER_US,
    parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
    parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
    parameter int POS_MIN_US   = DEF_POS_MIN_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                pwm_i,
    output logic [US_CNT_W-1:0] width_us_o,
    output logic [POS_W-1:0]    pos_o,
    output logic                valid_o,
    output logic                err_o,
    output logic                locked_o
);

    localparam int PRESC_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT_US + 1);

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICKS_PER_US - 1);
    localparam logic [US_CNT_W-1:0] MIN_CNT    = US_CNT_W'(MIN_PULSE_US);
    localparam logic [US_CNT_W-1:0] MAX_CNT    = US_CNT_W'(MAX_PULSE_US);
    localparam logic [US_CNT_W-1:0] ABORT_CNT  = US_CNT_W'(MAX_PULSE_US + 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_US - 1);
    localparam logic [TMO_W-1:0]    TMO_SAT    = TMO_W'(TIMEOUT_US);

    logic pwm_level, pwm_rise, pwm_fall;

    rx_state_e           state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [US_CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [US_CNT_W-1:0] width_q, width_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                locked_q, locked_d;

    logic                us_tick;
    logic                tmo_expire;
    logic [US_CNT_W-1:0] cnt_inc;

    // NOTE: the synchroniser resets high so releasing reset mid-pulse cannot fake a rise.
    rc_servo_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (pwm_i),
        .level_o (pwm_level),
        .rise_o  (pwm_rise),
        .fall_o  (pwm_fall)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        us_tick    = (presc_q == PRESC_LAST);
        presc_d    = (pwm_rise || us_tick) ? '0 : presc_q + 1'b1;
        cnt_inc    = cnt_q + US_CNT_W'(us_tick);
        tmo_expire = us_tick && (tmo_q == TMO_LAST);

        tmo_d = tmo_q;
        if (pwm_rise) begin
            tmo_d = '0;
        end else if (us_tick && (tmo_q != TMO_SAT)) begin
            tmo_d = tmo_q + 1'b1;
        end

        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = tmo_expire ? 1'b0 : locked_q;

        unique case (state_q)
            WAIT_LOW: begin
                if (!pwm_level) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (pwm_rise) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (pwm_fall) begin
                    state_d = WAIT_RISE;
                    // A valid fall overrides a timeout landing in the same cycle.
                    if (cnt_inc >= MIN_CNT && cnt_inc <= MAX_CNT) begin
                        width_d  = cnt_inc;
                        pos_d    = width_to_pos(cnt_inc, POS_MIN_US);
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_inc == ABORT_CNT) begin
                    err_d   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= WAIT_LOW;
            presc_q  <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            width_q  <= '0;
            pos_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            width_q  <= width_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign width_us_o = width_q;
    assign pos_o      = pos_q;
    assign valid_o    = valid_q;
    assign err_o      = err_q;
    assign locked_o   = locked_q;

endmodule
